// File: rtl/vga_pkg.sv
// Shared constants, types and the double-dabble adjust helper for the score overlay.
package vga_pkg;

    localparam int GLYPH_W      = 8;
    localparam int GLYPH_H      = 8;
    localparam int SCORE_DIGITS = 3;
    localparam int BCD_ITERS    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = adj[i*4 +: 4];
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/score_font_rom.sv
// 5x7 decimal digit glyphs in an 8x8 cell; row 7, columns 5-7 and codes 10-15 are dark.
module score_font_rom (
    input  logic [3:0] digit,
    input  logic [2:0] gy,
    input  logic [2:0] gx,
    output logic       pixel
);

    logic [34:0] w_glyph;
    logic [4:0]  w_row;

    // Glyph lookup: seven 5-bit rows packed top row first, MSB is the leftmost column.
    always_comb begin
        w_glyph = 35'd0;
        case (digit)
            4'd0:    w_glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            4'd1:    w_glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            4'd2:    w_glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            4'd3:    w_glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            4'd4:    w_glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            4'd5:    w_glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            4'd6:    w_glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            4'd7:    w_glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            4'd8:    w_glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9:    w_glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            default: w_glyph = 35'd0;
        endcase
    end

    // Row and column select within the glyph.
    always_comb begin
        w_row = 5'd0;
        case (gy)
            3'd0:    w_row = w_glyph[34:30];
            3'd1:    w_row = w_glyph[29:25];
            3'd2:    w_row = w_glyph[24:20];
            3'd3:    w_row = w_glyph[19:15];
            3'd4:    w_row = w_glyph[14:10];
            3'd5:    w_row = w_glyph[9:5];
            3'd6:    w_row = w_glyph[4:0];
            default: w_row = 5'd0;
        endcase
        pixel = 1'b0;
        case (gx)
            3'd0:    pixel = w_row[4];
            3'd1:    pixel = w_row[3];
            3'd2:    pixel = w_row[2];
            3'd3:    pixel = w_row[1];
            3'd4:    pixel = w_row[0];
            default: pixel = 1'b0;
        endcase
    end

endmodule

// File: rtl/vga_score_overlay.sv
// Overlays the score as up to three decimal digits on the board RGB stream, one-cycle latency.
// Binary-to-BCD runs once per frame so the displayed digits only change during blanking.
module vga_score_overlay
    import vga_pkg::*;
#(
    parameter logic [9:0] SCORE_X    = 10'd8,
    parameter logic [9:0] SCORE_Y    = 10'd8,
    parameter int         SCALE_LOG2 = 2,
    parameter logic [2:0] FG_RGB     = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] score_in,
    input  logic       frame_start,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic       R_in,
    input  logic       G_in,
    input  logic       B_in,
    output logic       R_out,
    output logic       G_out,
    output logic       B_out,
    output logic       busy
);

    localparam logic [9:0] CELL_W    = 10'(GLYPH_W << SCALE_LOG2);
    localparam logic [9:0] CELL_H    = 10'(GLYPH_H << SCALE_LOG2);
    localparam logic [9:0] BOX_W     = 10'(SCORE_DIGITS * (GLYPH_W << SCALE_LOG2));
    localparam logic [3:0] LAST_ITER = 4'(BCD_ITERS - 1);
    localparam int         CELL_SH   = $clog2(GLYPH_W) + SCALE_LOG2;

    conv_state_t r_state;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_iter;
    logic        r_busy;
    bcd_digit_t  r_hund;
    bcd_digit_t  r_tens;
    bcd_digit_t  r_units;
    logic [2:0]  r_rgb;

    logic [11:0] w_bcd_adj;
    logic        w_in_box;
    logic [9:0]  w_col_off;
    logic [9:0]  w_row_off;
    logic [1:0]  w_digit_idx;
    logic [2:0]  w_gx;
    logic [2:0]  w_gy;
    bcd_digit_t  w_digit;
    logic        w_blank;
    logic        w_font_px;
    logic        w_fg;

    assign w_bcd_adj = bcd_adjust(r_bcd);

    // Converter FSM: latch score in blanking, eight adjust-and-shift steps, then publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= 8'd0;
            r_bcd   <= 12'd0;
            r_iter  <= 4'd0;
            r_busy  <= 1'b0;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_bin   <= score_in;
                        r_bcd   <= 12'd0;
                        r_iter  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= 20'({w_bcd_adj, r_bin} << 1);
                    r_iter         <= r_iter + 4'd1;
                    if (r_iter == LAST_ITER) begin
                        r_state <= COMMIT;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                COMMIT: begin
                    r_hund  <= r_bcd[11:8];
                    r_tens  <= r_bcd[7:4];
                    r_units <= r_bcd[3:0];
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Range checks happen before subtraction so columns left of the box cannot wrap into it.
    assign w_in_box    = (col >= SCORE_X) && (col < SCORE_X + BOX_W) &&
                         (row >= SCORE_Y) && (row < SCORE_Y + CELL_H);
    assign w_col_off   = col - SCORE_X;
    assign w_row_off   = row - SCORE_Y;
    assign w_digit_idx = 2'(w_col_off >> CELL_SH);
    assign w_gx        = 3'(w_col_off >> SCALE_LOG2);
    assign w_gy        = 3'(w_row_off >> SCALE_LOG2);

    // Digit select with leading-zero blanking; units is always drawn.
    always_comb begin
        w_digit = r_units;
        w_blank = 1'b0;
        case (w_digit_idx)
            2'd0: begin
                w_digit = r_hund;
                w_blank = (r_hund == 4'd0);
            end
            2'd1: begin
                w_digit = r_tens;
                w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
            end
            2'd2: begin
                w_digit = r_units;
                w_blank = 1'b0;
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b1;
            end
        endcase
    end

    score_font_rom u_font (
        .digit (w_digit),
        .gy    (w_gy),
        .gx    (w_gx),
        .pixel (w_font_px)
    );

    assign w_fg = w_in_box && !w_blank && w_font_px && (CELL_W != 10'd0);

    // Pixel pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= 3'b000;
        end else if (w_fg) begin
            r_rgb <= FG_RGB;
        end else begin
            r_rgb <= {R_in, G_in, B_in};
        end
    end

    assign R_out = r_rgb[2];
    assign G_out = r_rgb[1];
    assign B_out = r_rgb[0];
    assign busy  = r_busy;

endmodule

// File: tb/tb_vga_score_overlay.sv
// Directed bench for vga_score_overlay: vector tables, model-checked row sweeps, conversion timing.
module tb_vga_score_overlay;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] score_in;
    logic       frame_start;
    logic [9:0] row;
    logic [9:0] col;
    logic       R_in, G_in, B_in;
    logic       R_out, G_out, B_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic [2:0] rgb;
        logic [2:0] exp;
    } vec_t;

    vec_t v0[11];
    vec_t v1[11];

    localparam bit [4:0] FONT [10][7] = '{
        '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
        '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}
    };

    vga_score_overlay dut (
        .clk         (clk),
        .reset       (reset),
        .score_in    (score_in),
        .frame_start (frame_start),
        .row         (row),
        .col         (col),
        .R_in        (R_in),
        .G_in        (G_in),
        .B_in        (B_in),
        .R_out       (R_out),
        .G_out       (G_out),
        .B_out       (B_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check3(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Box at cols [8,104), rows [8,40), 32-pixel cells, 4x magnification.
    function automatic logic [2:0] model(input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] u, input logic [9:0] r,
                                         input logic [9:0] c, input logic [2:0] rgb);
        int off, idx, gx, gy;
        logic [3:0] d;
        logic blank;
        if (c < 10'd8 || c >= 10'd104 || r < 10'd8 || r >= 10'd40) return rgb;
        off = int'(c) - 8;
        idx = off / 32;
        gx  = (off % 32) / 4;
        gy  = (int'(r) - 8) / 4;
        case (idx)
            0:       begin d = h; blank = (h == 4'd0); end
            1:       begin d = t; blank = (h == 4'd0) && (t == 4'd0); end
            default: begin d = u; blank = 1'b0; end
        endcase
        if (blank || gx > 4 || gy > 6) return rgb;
        if (FONT[d][gy][4-gx]) return 3'b111;
        return rgb;
    endfunction

    // Present one pixel, scramble the inputs right after the capturing edge, check one cycle later.
    task automatic apply(input logic [9:0] r, input logic [9:0] c, input logic [2:0] rgb,
                         input logic [2:0] exp, input string nm);
        row = r;
        col = c;
        {R_in, G_in, B_in} = rgb;
        @(posedge clk);
        #1;
        row = 10'd0;
        col = 10'd0;
        {R_in, G_in, B_in} = ~exp;
        @(negedge clk);
        check3($sformatf("%s r%0d c%0d", nm, r, c), {R_out, G_out, B_out}, exp);
    endtask

    task automatic sweep(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                         input string nm);
        logic [9:0] rows[6];
        rows = '{10'd8, 10'd20, 10'd35, 10'd39, 10'd7, 10'd40};
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 108; c++) begin
                logic [9:0] cc;
                logic [2:0] rgb;
                cc  = 10'(c);
                rgb = 3'(c) ^ rows[i][2:0];
                apply(rows[i], cc, rgb, model(h, t, u, rows[i], cc, rgb), nm);
            end
        end
    endtask

    // Pulse frame_start and check busy over the following ten cycles; optional retrigger at k=rk.
    task automatic convert(input logic [7:0] s, input int rk, input logic [7:0] s2);
        score_in    = s;
        frame_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            frame_start = (k == rk);
            score_in    = (rk >= 0 && k >= rk) ? s2 : s;
            check1($sformatf("busy_%0d_k%0d", s, k), busy, (k < 9));
        end
    endtask

    initial begin
        v0[0]  = '{10'd8,  10'd76,  3'b000, 3'b111};
        v0[1]  = '{10'd8,  10'd72,  3'b000, 3'b000};
        v0[2]  = '{10'd8,  10'd88,  3'b101, 3'b101};
        v0[3]  = '{10'd8,  10'd12,  3'b000, 3'b000};
        v0[4]  = '{10'd8,  10'd44,  3'b000, 3'b000};
        v0[5]  = '{10'd8,  10'd7,   3'b010, 3'b010};
        v0[6]  = '{10'd12, 10'd72,  3'b000, 3'b111};
        v0[7]  = '{10'd36, 10'd76,  3'b000, 3'b000};
        v0[8]  = '{10'd40, 10'd76,  3'b001, 3'b001};
        v0[9]  = '{10'd8,  10'd104, 3'b110, 3'b110};
        v0[10] = '{10'd8,  10'd103, 3'b000, 3'b000};

        v1[0]  = '{10'd8,  10'd16,  3'b000, 3'b111};
        v1[1]  = '{10'd8,  10'd12,  3'b100, 3'b100};
        v1[2]  = '{10'd8,  10'd40,  3'b000, 3'b111};
        v1[3]  = '{10'd8,  10'd56,  3'b000, 3'b111};
        v1[4]  = '{10'd8,  10'd60,  3'b011, 3'b011};
        v1[5]  = '{10'd8,  10'd72,  3'b000, 3'b111};
        v1[6]  = '{10'd32, 10'd72,  3'b000, 3'b000};
        v1[7]  = '{10'd32, 10'd76,  3'b000, 3'b111};
        v1[8]  = '{10'd20, 10'd48,  3'b000, 3'b111};
        v1[9]  = '{10'd20, 10'd44,  3'b000, 3'b000};
        v1[10] = '{10'd8,  10'd7,   3'b101, 3'b101};

        reset = 1'b1;
        frame_start = 1'b0;
        score_in = 8'd0;
        row = 10'd8;
        col = 10'd76;
        {R_in, G_in, B_in} = 3'b111;
        repeat (3) @(negedge clk);
        check3("reset_rgb", {R_out, G_out, B_out}, 3'b000);
        check1("reset_busy", busy, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) apply(v0[i].row, v0[i].col, v0[i].rgb, v0[i].exp, $sformatf("v0_%0d", i));
        sweep(4'd0, 4'd0, 4'd0, "sweep_000");

        convert(8'd173, -1, 8'd0);
        for (int i = 0; i < 11; i++) apply(v1[i].row, v1[i].col, v1[i].rgb, v1[i].exp, $sformatf("v1_%0d", i));
        sweep(4'd1, 4'd7, 4'd3, "sweep_173");

        convert(8'd7, -1, 8'd0);
        apply(10'd8, 10'd16, 3'b011, 3'b011, "hund_blank_7");
        apply(10'd8, 10'd72, 3'b000, 3'b111, "units_7");
        sweep(4'd0, 4'd0, 4'd7, "sweep_7");

        // Score changes mid-frame without frame_start must not reach the display.
        convert(8'd42, -1, 8'd0);
        score_in = 8'd200;
        repeat (20) @(negedge clk);
        sweep(4'd0, 4'd4, 4'd2, "sweep_42_held");
        convert(8'd200, -1, 8'd0);
        sweep(4'd2, 4'd0, 4'd0, "sweep_200");

        // Reset asserted on the fourth busy cycle aborts the conversion.
        score_in = 8'd99;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check1("busy_before_abort", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check1("busy_after_abort", busy, 1'b0);
        reset = 1'b0;
        sweep(4'd0, 4'd0, 4'd0, "sweep_aborted");
        convert(8'd99, -1, 8'd0);
        sweep(4'd0, 4'd9, 4'd9, "sweep_99");

        // Retrigger while busy is ignored; the first latched score wins.
        convert(8'd150, 3, 8'd250);
        sweep(4'd1, 4'd5, 4'd0, "sweep_150_retrig");

        // Reset and frame_start together: reset wins.
        reset = 1'b1;
        frame_start = 1'b1;
        score_in = 8'd255;
        @(negedge clk);
        check1("busy_rst_fs", busy, 1'b0);
        reset = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        check1("busy_rst_fs_after", busy, 1'b0);
        apply(10'd8, 10'd76, 3'b000, 3'b111, "rst_fs_units0");
        apply(10'd8, 10'd16, 3'b000, 3'b000, "rst_fs_hund_blank");

        convert(8'd255, -1, 8'd0);
        sweep(4'd2, 4'd5, 4'd5, "sweep_255");
        convert(8'd100, -1, 8'd0);
        sweep(4'd1, 4'd0, 4'd0, "sweep_100");
        convert(8'd5, -1, 8'd0);
        sweep(4'd0, 4'd0, 4'd5, "sweep_5");
        convert(8'd0, -1, 8'd0);
        sweep(4'd0, 4'd0, 4'd0, "sweep_0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
